// File: rtl/ram_writer_ctrl_if.sv
// ram_writer_ctrl_if -- signal bundle between a RAM-writer FIFO/AXI engine
// and its ring-buffer address controller.
//
// Ports (as interface members):
//   cfg_base   ring-buffer start byte address
//   cfg_beats  ring length in beats
//   cfg_enable level run request
//   cfg_clear  one-cycle pulse clearing the sticky overflow/underflow flags
//   reading    writer accepted a sample this cycle
//   writing    writer emitted a beat to memory this cycle
//   address    byte address tagged onto the next accepted sample
//   stream_en  upstream tvalid gate
//   busy       controller in RUN or DRAIN
//   in_flight  samples currently held in the writer FIFO
//   wr_idx     beats completed in the current lap
//   lap_count  completed laps (mod 2^16)
//   irq_half   one-cycle pulse when wr_idx reaches half the ring
//   irq_wrap   one-cycle pulse when wr_idx wraps to 0
//   overflow   sticky: sample accepted while FIFO full
//   underflow  sticky: beat emitted while FIFO empty
//   cfg_error  configuration rejected (ERROR state)
//   state      controller state code
//
// Modports: slave = controller side, master = stimulus/writer side.
// ADDR_WIDTH must match the controller's ADDR_WIDTH.
interface ram_writer_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] cfg_base;
  logic [23:0]           cfg_beats;
  logic                  cfg_enable;
  logic                  cfg_clear;
  logic                  reading;
  logic                  writing;
  logic [ADDR_WIDTH-1:0] address;
  logic                  stream_en;
  logic                  busy;
  logic [9:0]            in_flight;
  logic [23:0]           wr_idx;
  logic [15:0]           lap_count;
  logic                  irq_half;
  logic                  irq_wrap;
  logic                  overflow;
  logic                  underflow;
  logic                  cfg_error;
  logic [1:0]            state;

  modport slave (
    input  cfg_base, cfg_beats, cfg_enable, cfg_clear, reading, writing,
    output address, stream_en, busy, in_flight, wr_idx, lap_count,
           irq_half, irq_wrap, overflow, underflow, cfg_error, state
  );

  modport master (
    output cfg_base, cfg_beats, cfg_enable, cfg_clear, reading, writing,
    input  address, stream_en, busy, in_flight, wr_idx, lap_count,
           irq_half, irq_wrap, overflow, underflow, cfg_error, state
  );
endinterface

// File: rtl/ram_writer_ctrl.sv
// ram_writer_ctrl -- ring-buffer address and bookkeeping controller for a
// streaming RAM writer. Hands out one byte address per accepted sample,
// tracks FIFO occupancy between sample acceptance and beat write-out,
// counts completed beats/laps and raises half/wrap interrupts.
//
// Ports:
//   aclk     sole clock
//   aresetn  asynchronous active-low reset
//   bus      ram_writer_ctrl_if.slave (configuration, reading/writing
//            strobes in; address, status, counters and interrupts out)
//
// Every output is a flop. address is the value for the sample accepted in
// the current cycle, so it is already valid when reading rises.
module ram_writer_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int BEAT_BYTES = 4,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 512
) (
  input logic              aclk,
  input logic              aresetn,
  ram_writer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam logic [23:0]           BURST_LEN_W   = 24'(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES_W = ADDR_WIDTH'(BURST_LEN * BEAT_BYTES);
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES_W  = ADDR_WIDTH'(BEAT_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO     = {ADDR_WIDTH{1'b0}};
  localparam logic [9:0]            DEPTH_W       = 10'(FIFO_DEPTH);

  // Registered state
  state_t                state_r;
  logic [ADDR_WIDTH-1:0] base_r;
  logic [23:0]           beats_r;
  logic [23:0]           rd_idx_r;
  logic [ADDR_WIDTH-1:0] address_r;
  logic                  stream_en_r;
  logic                  busy_r;
  logic [9:0]            in_flight_r;
  logic [23:0]           wr_idx_r;
  logic [15:0]           lap_count_r;
  logic                  irq_half_r;
  logic                  irq_wrap_r;
  logic                  overflow_r;
  logic                  underflow_r;
  logic                  cfg_error_r;

  // Next-cycle values
  state_t                state_s;
  logic                  cfg_bad_s;
  logic                  enter_run_s;
  logic                  active_s;
  logic [ADDR_WIDTH-1:0] base_s;
  logic [23:0]           beats_s;
  logic [23:0]           rd_idx_s;
  logic [ADDR_WIDTH-1:0] address_s;
  logic [9:0]            in_flight_s;
  logic [23:0]           wr_idx_s;
  logic [15:0]           lap_count_s;
  logic                  irq_half_s;
  logic                  irq_wrap_s;
  logic                  overflow_s;
  logic                  underflow_s;

  // Configuration legality and next-state selection
  always_comb begin
    cfg_bad_s = (bus.cfg_beats == 24'd0) ||
                ((bus.cfg_beats % BURST_LEN_W) != 24'd0) ||
                ((bus.cfg_base % BURST_BYTES_W) != ADDR_ZERO);
    state_s   = state_r;
    case (state_r)
      IDLE: begin
        if (bus.cfg_enable) begin
          state_s = cfg_bad_s ? ERROR : RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (!bus.cfg_enable) begin
          state_s = DRAIN;
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        // Leave only once the FIFO is empty and nothing moves this cycle.
        if ((in_flight_r == 10'd0) && !bus.reading && !bus.writing) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      ERROR: begin
        if (!bus.cfg_enable) begin
          state_s = IDLE;
        end else begin
          state_s = ERROR;
        end
      end
      default: state_s = IDLE;
    endcase
    enter_run_s = (state_r == IDLE) && (state_s == RUN);
    active_s    = (state_r == RUN) || (state_r == DRAIN);
  end

  // Datapath next values: address ring, occupancy, write index, flags
  always_comb begin
    base_s      = base_r;
    beats_s     = beats_r;
    rd_idx_s    = rd_idx_r;
    address_s   = address_r;
    in_flight_s = in_flight_r;
    wr_idx_s    = wr_idx_r;
    lap_count_s = lap_count_r;
    irq_half_s  = 1'b0;
    irq_wrap_s  = 1'b0;

    // Clear is applied first so that a new event in the same cycle wins.
    overflow_s  = bus.cfg_clear ? 1'b0 : overflow_r;
    underflow_s = bus.cfg_clear ? 1'b0 : underflow_r;
    if (bus.reading && (in_flight_r == DEPTH_W)) begin
      overflow_s = 1'b1;
    end else begin
      overflow_s = overflow_s;
    end
    if (bus.writing && (in_flight_r == 10'd0)) begin
      underflow_s = 1'b1;
    end else begin
      underflow_s = underflow_s;
    end

    // Occupancy saturates at both ends; simultaneous in/out is a no-op.
    if (bus.reading && !bus.writing) begin
      if (in_flight_r != DEPTH_W) begin
        in_flight_s = in_flight_r + 10'd1;
      end else begin
        in_flight_s = in_flight_r;
      end
    end else if (bus.writing && !bus.reading) begin
      if (in_flight_r != 10'd0) begin
        in_flight_s = in_flight_r - 10'd1;
      end else begin
        in_flight_s = in_flight_r;
      end
    end else begin
      in_flight_s = in_flight_r;
    end

    // Sample address walks the ring and snaps back to the latched base.
    if (active_s && bus.reading) begin
      if (rd_idx_r == (beats_r - 24'd1)) begin
        rd_idx_s  = 24'd0;
        address_s = base_r;
      end else begin
        rd_idx_s  = rd_idx_r + 24'd1;
        address_s = address_r + BEAT_BYTES_W;
      end
    end else begin
      rd_idx_s  = rd_idx_r;
      address_s = address_r;
    end

    // Completed-beat index; interrupts are registered with the index so
    // they appear in the first cycle showing the new wr_idx.
    if (active_s && bus.writing) begin
      if (wr_idx_r == (beats_r - 24'd1)) begin
        wr_idx_s    = 24'd0;
        irq_wrap_s  = 1'b1;
        lap_count_s = lap_count_r + 16'd1;
      end else begin
        wr_idx_s   = wr_idx_r + 24'd1;
        irq_half_s = ((wr_idx_r + 24'd1) == (beats_r >> 1));
      end
    end else begin
      wr_idx_s = wr_idx_r;
    end

    // Starting a run discards all previous progress and latches the ring.
    if (enter_run_s) begin
      base_s      = bus.cfg_base;
      beats_s     = bus.cfg_beats;
      address_s   = bus.cfg_base;
      rd_idx_s    = 24'd0;
      wr_idx_s    = 24'd0;
      in_flight_s = 10'd0;
      lap_count_s = 16'd0;
      overflow_s  = 1'b0;
      underflow_s = 1'b0;
      irq_half_s  = 1'b0;
      irq_wrap_s  = 1'b0;
    end else begin
      base_s  = base_r;
      beats_s = beats_r;
    end
  end

  // State and output registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r     <= IDLE;
      base_r      <= ADDR_ZERO;
      beats_r     <= 24'd0;
      rd_idx_r    <= 24'd0;
      address_r   <= ADDR_ZERO;
      stream_en_r <= 1'b0;
      busy_r      <= 1'b0;
      in_flight_r <= 10'd0;
      wr_idx_r    <= 24'd0;
      lap_count_r <= 16'd0;
      irq_half_r  <= 1'b0;
      irq_wrap_r  <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      cfg_error_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      base_r      <= base_s;
      beats_r     <= beats_s;
      rd_idx_r    <= rd_idx_s;
      address_r   <= address_s;
      stream_en_r <= (state_s == RUN);
      busy_r      <= (state_s == RUN) || (state_s == DRAIN);
      in_flight_r <= in_flight_s;
      wr_idx_r    <= wr_idx_s;
      lap_count_r <= lap_count_s;
      irq_half_r  <= irq_half_s;
      irq_wrap_r  <= irq_wrap_s;
      overflow_r  <= overflow_s;
      underflow_r <= underflow_s;
      cfg_error_r <= (state_s == ERROR);
    end
  end

  assign bus.state     = state_r;
  assign bus.address   = address_r;
  assign bus.stream_en = stream_en_r;
  assign bus.busy      = busy_r;
  assign bus.in_flight = in_flight_r;
  assign bus.wr_idx    = wr_idx_r;
  assign bus.lap_count = lap_count_r;
  assign bus.irq_half  = irq_half_r;
  assign bus.irq_wrap  = irq_wrap_r;
  assign bus.overflow  = overflow_r;
  assign bus.underflow = underflow_r;
  assign bus.cfg_error = cfg_error_r;

endmodule

// File: tb/tb_ram_writer_ctrl.sv
// tb_ram_writer_ctrl -- scoreboard bench for ram_writer_ctrl. Inputs are
// driven on the falling edge; a reference model computes the outputs the
// DUT must show after the next rising edge and queues them; a monitor pops
// and compares one expectation per rising edge.
module tb_ram_writer_ctrl;

  localparam int DEPTH = 512;

  logic aclk;
  logic aresetn;

  ram_writer_ctrl_if #(.ADDR_WIDTH(32)) bus ();

  ram_writer_ctrl #(
    .ADDR_WIDTH(32),
    .BEAT_BYTES(4),
    .BURST_LEN (16),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .bus    (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [1:0]  state;
    logic        stream_en;
    logic        busy;
    logic        cfg_error;
    logic [31:0] address;
    logic [9:0]  in_flight;
    logic [23:0] wr_idx;
    logic [15:0] lap_count;
    logic        irq_half;
    logic        irq_wrap;
    logic        overflow;
    logic        underflow;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] tb_base  = 32'h0;
  int          tb_beats = 0;

  // Reference model: 0 idle, 1 run, 2 drain, 3 error
  int          m_state;
  logic [31:0] m_base;
  int          m_beats, m_rd, m_wr, m_infl, m_lap;
  bit          m_ovf, m_unf, m_irq_h, m_irq_w;

  task automatic model_reset();
    m_state = 0; m_base = 32'h0; m_beats = 0; m_rd = 0; m_wr = 0;
    m_infl = 0; m_lap = 0; m_ovf = 0; m_unf = 0; m_irq_h = 0; m_irq_w = 0;
  endtask

  task automatic model_step(input bit en, input bit clr, input bit rd, input bit wr,
                            input logic [31:0] base, input int beats);
    int  cur = m_state;
    int  old_infl = m_infl;
    bit  bad;
    m_irq_h = 0;
    m_irq_w = 0;
    if (clr) begin m_ovf = 0; m_unf = 0; end
    if (rd && old_infl == DEPTH) m_ovf = 1;
    if (wr && old_infl == 0) m_unf = 1;
    if (rd && !wr && old_infl < DEPTH) m_infl = old_infl + 1;
    if (wr && !rd && old_infl > 0) m_infl = old_infl - 1;
    if (cur == 1 || cur == 2) begin
      if (rd) m_rd = (m_rd + 1) % m_beats;
      if (wr) begin
        m_wr = (m_wr + 1) % m_beats;
        if (m_wr == 0) begin
          m_irq_w = 1;
          m_lap = (m_lap + 1) % 65536;
        end else if (m_wr == m_beats / 2) begin
          m_irq_h = 1;
        end
      end
    end
    case (cur)
      0: if (en) begin
           bad = (beats == 0) || (beats % 16 != 0) || (base % 64 != 0);
           if (bad) m_state = 3;
           else begin
             m_state = 1; m_base = base; m_beats = beats; m_rd = 0; m_wr = 0;
             m_infl = 0; m_lap = 0; m_ovf = 0; m_unf = 0;
           end
         end
      1: if (!en) m_state = 2;
      2: if (old_infl == 0 && !rd && !wr) m_state = 0;
      3: if (!en) m_state = 0;
      default: m_state = 0;
    endcase
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.state     = 2'(m_state);
    e.stream_en = (m_state == 1);
    e.busy      = (m_state == 1) || (m_state == 2);
    e.cfg_error = (m_state == 3);
    e.address   = m_base + 32'(m_rd * 4);
    e.in_flight = 10'(m_infl);
    e.wr_idx    = 24'(m_wr);
    e.lap_count = 16'(m_lap);
    e.irq_half  = m_irq_h;
    e.irq_wrap  = m_irq_w;
    e.overflow  = m_ovf;
    e.underflow = m_unf;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk("state",     32'(bus.state),     32'(e.state));
    chk("stream_en", 32'(bus.stream_en), 32'(e.stream_en));
    chk("busy",      32'(bus.busy),      32'(e.busy));
    chk("cfg_error", 32'(bus.cfg_error), 32'(e.cfg_error));
    chk("address",   bus.address,        e.address);
    chk("in_flight", 32'(bus.in_flight), 32'(e.in_flight));
    chk("wr_idx",    32'(bus.wr_idx),    32'(e.wr_idx));
    chk("lap_count", 32'(bus.lap_count), 32'(e.lap_count));
    chk("irq_half",  32'(bus.irq_half),  32'(e.irq_half));
    chk("irq_wrap",  32'(bus.irq_wrap),  32'(e.irq_wrap));
    chk("overflow",  32'(bus.overflow),  32'(e.overflow));
    chk("underflow", 32'(bus.underflow), 32'(e.underflow));
  endtask

  // Monitor: one queued expectation per rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge aclk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_all(e);
      end
    end
  end

  task automatic drive(input bit en, input bit clr, input bit rd, input bit wr);
    @(negedge aclk);
    aresetn        = 1'b1;
    bus.cfg_enable = en;
    bus.cfg_clear  = clr;
    bus.reading    = rd;
    bus.writing    = wr;
    bus.cfg_base   = tb_base;
    bus.cfg_beats  = 24'(tb_beats);
    model_step(en, clr, rd, wr, tb_base, tb_beats);
    exp_q.push_back(model_out());
    cyc++;
  endtask

  // Asynchronous reset away from any rising edge, checked before the next one
  task automatic do_reset();
    @(negedge aclk);
    aresetn        = 1'b0;
    bus.cfg_enable = 1'b0;
    bus.cfg_clear  = 1'b0;
    bus.reading    = 1'b0;
    bus.writing    = 1'b0;
    model_reset();
    exp_q.delete();
    #1;
    chk_all(model_out());
  endtask

  initial begin
    bit en;
    aresetn        = 1'b0;
    bus.cfg_base   = 32'h0;
    bus.cfg_beats  = 24'd0;
    bus.cfg_enable = 1'b0;
    bus.cfg_clear  = 1'b0;
    bus.reading    = 1'b0;
    bus.writing    = 1'b0;
    model_reset();
    repeat (2) @(posedge aclk);
    do_reset();
    repeat (3) drive(0, 0, 0, 0);

    // Address ring over 33 samples, then half/wrap interrupts over 33 beats
    tb_base = 32'h1000_0000; tb_beats = 32;
    drive(1, 0, 0, 0);
    repeat (33) drive(1, 0, 1, 0);
    repeat (33) drive(1, 0, 0, 1);
    drive(0, 0, 0, 0);
    repeat (2) drive(0, 0, 0, 0);

    // Rejected configurations
    tb_beats = 20;
    repeat (3) drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    tb_base = 32'h1000_0020; tb_beats = 32;
    repeat (3) drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    tb_base = 32'h1000_0000; tb_beats = 0;
    repeat (2) drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);

    // Occupancy: balanced traffic, overflow, clear, underflow
    tb_base = 32'h2000_0040; tb_beats = 64;
    drive(1, 0, 0, 0);
    repeat (5) drive(1, 0, 1, 0);
    repeat (10) drive(1, 0, 1, 1);
    repeat (DEPTH - 5) drive(1, 0, 1, 0);
    drive(1, 0, 1, 0);
    drive(1, 1, 0, 0);
    drive(1, 1, 1, 0);
    drive(1, 1, 0, 0);
    repeat (DEPTH) drive(1, 0, 0, 1);
    drive(1, 0, 0, 1);
    drive(1, 1, 0, 1);
    drive(1, 1, 0, 0);

    // Drain with three samples outstanding
    repeat (3) drive(1, 0, 1, 0);
    drive(0, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 1);
    repeat (2) drive(0, 0, 0, 0);

    // Reset mid-run with seven samples outstanding; must stay idle afterwards
    tb_base = 32'h3000_0000; tb_beats = 48;
    drive(1, 0, 0, 0);
    repeat (7) drive(1, 0, 1, 0);
    do_reset();
    repeat (3) drive(0, 0, 0, 0);

    // Randomised traffic with config changes while running
    en = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        if ($urandom_range(0, 4) == 0) begin
          tb_beats = $urandom_range(0, 70);
          tb_base  = 32'($urandom_range(0, 4095));
        end else begin
          tb_beats = 16 * $urandom_range(1, 4);
          tb_base  = 32'h4000_0000 + 32'(64 * $urandom_range(0, 255));
        end
      end
      if ($urandom_range(0, 99) == 0) en = ~en;
      drive(en, ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 9) < (en ? 5 : 1)),
            ($urandom_range(0, 9) < (en ? 4 : 6)));
    end
    repeat (3) drive(0, 0, 0, 0);

    @(posedge aclk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
